integral_image_gen: RTL and testbench
=====================================

Name: integral_image_gen

Overview:
Converts the raster pixel stream of one core tile into its summed-area (integral) image. The face-detection core reads this image to evaluate eye, cheek, nose and mouth box sums with four-corner lookups. The block sits directly upstream of that core, between the tile pixel source and the core image memory loader. It uses one running row sum and one line buffer of the previous row's integral values.

Parameters:
MAX_W, 320, maximum tile width in pixels; sets the line-buffer depth
PIX_W, 8, input pixel width
SUM_W, 32, integral value width; arithmetic wraps modulo 2^SUM_W
DIM_W, 16, width of the width/height/coordinate fields

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame using width/height
width  in  DIM_W  tile width, latched on accepted start
height  in  DIM_W  tile height, latched on accepted start
in_valid  in  1  pixel valid
in_ready  out  1  pixel accepted when in_valid && in_ready
in_pixel  in  PIX_W  unsigned pixel, raster order
out_valid  out  1  integral value valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_data  out  SUM_W  I(x,y) = sum of pix[i,j] for i<=x, j<=y
out_addr  out  32  linear address y*width + x of out_data
busy  out  1  high in RUN and DRAIN
frame_done  out  1  one-cycle pulse when the last value is accepted
cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset is synchronous and active-high on clk.
  - Reset values: state=IDLE; x, y, row_sum, out_valid, frame_done, cfg_err, busy all 0; out_data and out_addr 0.
  - Line-buffer contents are not reset. Row 0 never reads them.
- State IDLE:
  - in_ready=0.
  - start with 1<=width<=MAX_W and height>=1: latch the dimensions, clear x, y and row_sum, go to RUN.
  - start with any other dimensions: pulse cfg_err for one cycle, stay IDLE.
- State RUN:
  - in_ready = !out_valid || out_ready (single-stage pipeline; no bubble under continuous flow).
  - On each accepted pixel:
    - s = (x==0 ? 0 : row_sum) + pixel.
    - prev = (y==0 ? 0 : lb[x]).
    - Register out_data = prev + s, out_addr = y*width + x, out_valid=1.
    - Write lb[x] = prev + s.
    - Set row_sum = s, then advance x. At x==width-1, x wraps to 0 and y increments.
  - Latency: accepted pixel to out_valid is exactly 1 cycle.
  - Line buffer reads return the old value when the same x is read and written in one cycle (read-before-write).
  - out_valid stays high, with out_data and out_addr held, until out_ready is sampled high.
  - After the pixel at (width-1, height-1) is accepted: go to DRAIN, in_ready=0.
- State DRAIN:
  - When the final value is accepted: pulse frame_done, go to IDLE.
  - A new start in the same cycle as frame_done is ignored.
- start while in RUN or DRAIN is ignored; no cfg_err is raised.
- Pixels presented outside RUN are not accepted.
- Width rules:
  - out_addr = y*width + x is computed with a multiply-free running counter that increments on every accept.
  - Sums wrap modulo 2^SUM_W.
  - 255*MAX_W*MAX_W fits in SUM_W=32, so no wrap occurs at the defaults.
- Reset mid-frame aborts the frame. The partial frame produces no frame_done, and the next start behaves as if the block had never run.
- width=1 is legal: every pixel is a row start, so row_sum is never added.

Decomposition:
- Shared package face_pkg holds:
  - pixel_t (PIX_W), sum_t (SUM_W), dim_t (DIM_W);
  - the constant MAX_W;
  - the state enum IDLE/RUN/DRAIN.
- Natural sub-module: iig_line_buffer.
  - MAX_W x SUM_W register array.
  - Asynchronous read, synchronous write, read-before-write.
  - Keep it separate so it can later be swapped for a block RAM.

Test Plan:
1. 2x2 frame, pixels 1,2,3,4, out_ready=1 -> out_data 1,3,4,10 at addr 0..3, each 1 cycle after its pixel; frame_done pulses once after addr 3.
2. 3x3 frame, all pixels 255 -> final out_data 2295 at addr 8. Row 0 gives 255,510,765; column 0 gives 255,510,765.
3. 4x2 frame, pixels 1..8, out_ready toggling 1,0,0,1 -> in_ready low whenever out_valid && !out_ready; out_data held stable. Values 1,3,6,10,6,14,24,36, none lost or duplicated.
4. start with width=0, then with width=MAX_W+1 -> cfg_err pulses each time; busy stays 0; in_ready stays 0.
5. Reset asserted after 3 pixels of a 4x4 frame -> all outputs are 0 the next cycle. A subsequent 2x2 frame of 1,2,3,4 gives 1,3,4,10, proving stale row_sum and line buffer have no effect.
6. start pulsed mid-frame with width=7, and 1x5 frame of all 1s -> first frame is unaffected. 1x5 output is 1,2,3,4,5 at addr 0..4.

Source files
------------

// File: rtl/face_pkg.sv
// Shared types and constants for the integral-image front end of the face-detection core.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package face_pkg;

  localparam int PIX_W = 8;    // input pixel width
  localparam int SUM_W = 32;   // integral value width, wraps modulo 2^SUM_W
  localparam int DIM_W = 16;   // width/height/coordinate field width
  localparam int MAX_W = 320;  // widest tile; sets the line-buffer depth

  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [SUM_W-1:0] sum_t;
  typedef logic [DIM_W-1:0] dim_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // A frame needs at least one pixel and must fit in the line buffer.
  function automatic logic dims_ok(input dim_t w, input dim_t h);
    return (w != '0) && (w <= dim_t'(MAX_W)) && (h != '0);
  endfunction

endpackage

// File: rtl/iig_line_buffer.sv
// One row of integral values, indexed by column.
// Latency: asynchronous read, write lands on the next clk edge; a same-address read sees the old value.
// Backpressure: none; the caller only writes on accepted pixels.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr/rd_data combinational read port.
// Kept as its own module so it can be swapped for a block RAM later.
module iig_line_buffer #(
  parameter int DEPTH = 320,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  // Contents are deliberately not reset: row 0 never reads them.
  logic [DW-1:0] mem [DEPTH];

  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/integral_image_gen.sv
// Turns a raster pixel stream of one tile into its summed-area image with linear addresses.
// Latency: accepted pixel to out_valid is exactly 1 cycle.
// Backpressure: single output register; in_ready drops while out_valid && !out_ready, no bubble under flow.
// Ports: clk, reset (sync, active-high); start/width/height frame setup; in_valid/in_ready/in_pixel
// pixel stream; out_valid/out_ready/out_data/out_addr integral stream; busy, frame_done, cfg_err status.
module integral_image_gen
  import face_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  dim_t        width,
  input  dim_t        height,
  input  logic        in_valid,
  output logic        in_ready,
  input  pixel_t      in_pixel,
  output logic        out_valid,
  input  logic        out_ready,
  output sum_t        out_data,
  output logic [31:0] out_addr,
  output logic        busy,
  output logic        frame_done,
  output logic        cfg_err
);

  localparam int LB_AW = $clog2(MAX_W);

  state_t      state, state_nxt;
  dim_t        x, y, w_q, h_q;
  sum_t        row_sum;
  logic [31:0] addr_cnt;

  logic pix_acc, out_acc, start_seen, cfg_ok, x_last, y_last;
  sum_t lb_rd, row_part, col_part, s_val, i_val;

  assign pix_acc = in_valid && in_ready;
  assign out_acc = out_valid && out_ready;
  // A start coinciding with frame_done still belongs to the finished frame and is dropped.
  assign start_seen = (state == IDLE) && start && !frame_done;
  assign cfg_ok     = dims_ok(width, height);
  assign x_last     = (x == w_q - dim_t'(1));
  assign y_last     = (y == h_q - dim_t'(1));

  // Row start ignores row_sum and row 0 ignores the line buffer, so neither needs clearing.
  assign row_part = (x == '0) ? '0 : row_sum;
  assign s_val    = row_part + sum_t'(in_pixel);
  assign col_part = (y == '0) ? '0 : lb_rd;
  assign i_val    = col_part + s_val;

  iig_line_buffer #(
    .DEPTH (MAX_W),
    .DW    (SUM_W),
    .AW    (LB_AW)
  ) u_lb (
    .clk     (clk),
    .wr_en   (pix_acc),
    .wr_addr (x[LB_AW-1:0]),
    .wr_data (i_val),
    .rd_addr (x[LB_AW-1:0]),
    .rd_data (lb_rd)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_seen && cfg_ok)          state_nxt = RUN;
      RUN:     if (pix_acc && x_last && y_last)   state_nxt = DRAIN;
      DRAIN:   if (out_acc)                       state_nxt = IDLE;
      default:                                    state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      RUN: begin
        in_ready = !out_valid || out_ready;
        busy     = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      default: ;
    endcase
  end

  // Datapath and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      w_q        <= '0;
      h_q        <= '0;
      row_sum    <= '0;
      addr_cnt   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      frame_done <= (state == DRAIN) && out_acc;
      cfg_err    <= start_seen && !cfg_ok;

      if (start_seen && cfg_ok) begin
        w_q      <= width;
        h_q      <= height;
        x        <= '0;
        y        <= '0;
        row_sum  <= '0;
        addr_cnt <= '0;
      end

      if (pix_acc) begin
        out_valid <= 1'b1;
        out_data  <= i_val;
        out_addr  <= addr_cnt;
        row_sum   <= s_val;
        // Running counter equals y*width + x without a multiplier.
        addr_cnt  <= addr_cnt + 32'd1;
        if (x_last) begin
          x <= '0;
          y <= y + dim_t'(1);
        end else begin
          x <= x + dim_t'(1);
        end
      end else if (out_acc) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_integral_image_gen.sv
// Self-checking bench for integral_image_gen against a direct summed-area reference.
// Latency: n/a (testbench).
// Backpressure: bench drives out_ready always-high, patterned, or random.
module tb_integral_image_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] width, height;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pixel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic        busy;
  logic        frame_done;
  logic        cfg_err;

  int total = 0;
  int bad   = 0;
  int pix [0:639];

  integral_image_gen dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .width      (width),
    .height     (height),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .busy       (busy),
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // I(x,y) as a plain double sum over the rectangle [0..x] x [0..y].
  function automatic logic [31:0] ref_val(input int w, input int idx);
    logic [31:0] s;
    int px, py;
    px = idx % w;
    py = idx / w;
    s  = 32'd0;
    for (int j = 0; j <= py; j++)
      for (int i = 0; i <= px; i++)
        s = s + 32'(pix[j*w + i]);
    return s;
  endfunction

  // rmode: 0 out_ready=1, 1 pattern 1,0,0,1, 2 random (with random input gaps).
  // mid: pulse an extra start (width=7) a few cycles into the frame.
  task automatic run_frame(input int w, input int h, input int rmode, input bit mid, input string tag);
    int n, sent, nout, cyc, budget, p_idx;
    bit p_acc, held;
    logic [31:0] hd, ha;
    n = w * h; sent = 0; nout = 0; cyc = 0; p_idx = 0;
    p_acc = 0; held = 0; hd = 0; ha = 0;
    budget = 20 * n + 50;

    @(negedge clk);
    start = 1'b1; width = 16'(w); height = 16'(h);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_run"}, busy, 1);

    while (nout < n && cyc < budget) begin
      if (p_acc) begin
        chk({tag, "_lat_vld"}, out_valid, 1);
        chk({tag, "_lat_addr"}, out_addr, p_idx);
      end
      if (held) begin
        chk({tag, "_hold_data"}, out_data, hd);
        chk({tag, "_hold_addr"}, out_addr, ha);
      end
      chk({tag, "_no_done"}, frame_done, 0);
      chk({tag, "_no_err"}, cfg_err, 0);

      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid = (sent < n) && (rmode != 2 || $urandom_range(0, 3) != 0);
      in_pixel = (sent < n) ? 8'(pix[sent]) : 8'd0;
      start    = mid && (cyc == 3);
      if (mid && cyc == 3) begin
        width = 16'd7; height = 16'd3;
      end
      #1;
      if (out_valid && !out_ready) chk({tag, "_stall_rdy"}, in_ready, 0);
      if (out_valid && out_ready) begin
        chk({tag, "_data"}, out_data, ref_val(w, nout));
        chk({tag, "_addr"}, out_addr, nout);
        nout++;
      end
      p_acc = in_valid && in_ready;
      if (p_acc) begin
        p_idx = sent;
        sent++;
      end
      held = out_valid && !out_ready;
      hd = out_data; ha = out_addr;
      cyc++;
      @(negedge clk);
    end

    start = 1'b0; in_valid = 1'b0;
    chk({tag, "_count"}, nout, n);
    chk({tag, "_done"}, frame_done, 1);
    chk({tag, "_busy_end"}, busy, 0);
    // A start arriving with frame_done must be ignored.
    start = 1'b1; width = 16'd2; height = 16'd2;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_once"}, frame_done, 0);
    chk({tag, "_ign_start"}, busy, 0);
    chk({tag, "_ign_err"}, cfg_err, 0);
  endtask

  initial begin
    int cw[3];
    int ch[3];
    int rw, rh;
    cw = '{0, 321, 5};
    ch = '{3, 2, 0};
    reset = 1'b1; start = 1'b0; width = '0; height = '0;
    in_valid = 1'b0; in_pixel = '0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_vld", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", cfg_err, 0);
    reset = 1'b0;

    // 2x2, 1..4, out_ready always high
    for (int i = 0; i < 4; i++) pix[i] = i + 1;
    run_frame(2, 2, 0, 0, "t1");

    // 3x3 all 255
    for (int i = 0; i < 9; i++) pix[i] = 255;
    run_frame(3, 3, 0, 0, "t2");

    // 4x2, 1..8, out_ready pattern 1,0,0,1
    for (int i = 0; i < 8; i++) pix[i] = i + 1;
    run_frame(4, 2, 1, 0, "t3");

    // Rejected starts
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b1; width = 16'(cw[k]); height = 16'(ch[k]); in_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("t4_err", cfg_err, 1);
      chk("t4_busy", busy, 0);
      chk("t4_rdy", in_ready, 0);
      @(negedge clk);
      chk("t4_err_pulse", cfg_err, 0);
      in_valid = 1'b0;
    end

    // Reset mid-frame after 3 pixels of a 4x4 frame
    @(negedge clk);
    start = 1'b1; width = 16'd4; height = 16'd4;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_pixel = 8'd200;
    repeat (3) @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("t5_vld", out_valid, 0);
    chk("t5_data", out_data, 0);
    chk("t5_addr", out_addr, 0);
    chk("t5_busy", busy, 0);
    chk("t5_rdy", in_ready, 0);
    chk("t5_done", frame_done, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) pix[i] = i + 1;
    run_frame(2, 2, 0, 0, "t5b");

    // Mid-frame start ignored, then width=1 frame
    for (int i = 0; i < 12; i++) pix[i] = (i * 37 + 11) % 256;
    run_frame(4, 3, 0, 1, "t6a");
    for (int i = 0; i < 5; i++) pix[i] = 1;
    run_frame(1, 5, 0, 0, "t6b");

    // Random frames under random backpressure
    for (int f = 0; f < 4; f++) begin
      rw = $urandom_range(1, 8);
      rh = $urandom_range(1, 6);
      for (int i = 0; i < rw * rh; i++) pix[i] = $urandom_range(0, 255);
      run_frame(rw, rh, 2, 0, "rnd");
    end

    // Widest legal tile
    for (int i = 0; i < 640; i++) pix[i] = $urandom_range(0, 255);
    run_frame(320, 2, 0, 0, "maxw");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
